multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main sequencing FSM for the multicycle MIPS variant. The single-cycle core uses separate instruction and data memories; this variant instead shares one unified memory port, one ALU and the PC adder across several cycles per instruction. The block decodes op/funct, steps the datapath through fetch/decode/execute/memory/writeback, and stalls on a memory ready handshake. Supported instructions: lw, sw, R-type (add, sub, and, or, slt), beq, bne, addi, ori, j.

Parameters:
RESET_STATE, S_FETCH, state entered on reset (fixed; changing it is not supported).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  instr[31:26] from the instruction register
funct  in  6  instr[5:0] from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  unified memory has completed the current read/write
mem_req  out  1  memory access request, held until mem_ready
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load enable
regdst  out  1  register destination: 1 = rd, 0 = rt
memtoreg  out  1  writeback source: 1 = memory data register, 0 = ALUOut
regwrite  out  1  register file write enable
alusrca  out  1  ALU A input: 0 = PC, 1 = register A
alusrcb  out  2  ALU B input: 00 = B, 01 = 4, 10 = extended immediate, 11 = extended immediate << 2
extop  out  1  immediate extension: 1 = zero-extend (ori), 0 = sign-extend
pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
pcen  out  1  PC load enable
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
illegal  out  1  one-cycle pulse when an unsupported op or funct is decoded
state_o  out  4  current state encoding, for debug

Behaviour:
- Registered state; all outputs are a combinational decode of the state (Moore), plus op/funct/zero/mem_ready where noted.
- Reset: state <= S_FETCH. While reset=1, pcen, irwrite, memwrite, regwrite, mem_req and illegal are forced to 0.
- States:
  - S_FETCH(0):
    - mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00.
    - irwrite and pcen assert only in the cycle mem_ready=1; the FSM then moves to S_DECODE. Otherwise it stays.
  - S_DECODE(1):
    - alusrca=0, alusrcb=11, aluop=add (branch target precomputed into ALUOut).
    - Next state by op: lw/sw -> S_MEMADR, R -> S_RTYPEEX, beq/bne -> S_BRANCH, addi/ori -> S_IMMEX, j -> S_JUMP.
    - Any other op -> S_FETCH with illegal=1.
  - S_MEMADR(2): alusrca=1, alusrcb=10, aluop=add. lw -> S_MEMRD; sw -> S_MEMWR.
  - S_MEMRD(3): mem_req=1, iord=1. Wait until mem_ready -> S_MEMWB.
  - S_MEMWB(4): regdst=0, memtoreg=1, regwrite=1 -> S_FETCH.
  - S_MEMWR(5): mem_req=1, iord=1, memwrite=1 (held until mem_ready) -> S_FETCH on mem_ready.
  - S_RTYPEEX(6):
    - alusrca=1, alusrcb=00, alucontrol from funct.
    - Unsupported funct -> S_FETCH with illegal=1 and no writeback. Otherwise -> S_RTYPEWB.
  - S_RTYPEWB(7): regdst=1, memtoreg=0, regwrite=1 -> S_FETCH.
  - S_BRANCH(8):
    - alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01.
    - pcen = zero XOR bne, where bne = (op==000101). -> S_FETCH.
  - S_IMMEX(9): alusrca=1, alusrcb=10, extop=(op==ori), alucontrol = ori ? or : add -> S_IMMWB.
  - S_IMMWB(10): regdst=0, memtoreg=0, regwrite=1 -> S_FETCH.
  - S_JUMP(11): pcsrc=10, pcen=1 -> S_FETCH.
  - Codes 12-15 are unreachable; any of them -> S_FETCH.
- Cycle counts with zero memory wait:

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R-type | 4 |
  | addi, ori | 4 |
  | beq, bne | 3 |
  | j | 3 |

  Each memory wait cycle adds one cycle.
- Opcodes:

  | Instruction | op |
  |---|---|
  | R-type | 000000 |
  | lw | 100011 |
  | sw | 101011 |
  | beq | 000100 |
  | bne | 000101 |
  | addi | 001000 |
  | ori | 001101 |
  | j | 000010 |

- Functs:

  | Instruction | funct |
  |---|---|
  | add | 100000 |
  | sub | 100010 |
  | and | 100100 |
  | or | 100101 |
  | slt | 101010 |

- Defaults: every output not listed for a state is 0. alucontrol defaults to 010.
- Boundary cases:
  - mem_ready asserted outside a mem_req state is ignored.
  - Reset during a memory wait returns to S_FETCH next cycle with no write strobe.
  - memwrite never asserts without mem_req=1 and iord=1.
  - op/funct are read only from the IR, which is stable after S_FETCH.

Decomposition:
- Package mips_mc_pkg holds:
  - the state_t enum (4-bit, encodings as above);
  - opcode and funct localparams;
  - alucontrol code localparams;
  - the aluop_t enum (ADD, SUB, FUNCT, OR).
- One combinational sub-module, mc_aludec: inputs aluop and funct; outputs alucontrol and funct_illegal.

Test Plan:
- reset=1 for 2 cycles, then mem_ready=1 constantly -> state_o=0 during reset; pcen=irwrite=0 during reset; first cycle after reset pcen=1, irwrite=1.
- lw (op=100011), mem_ready low for 2 cycles in S_MEMRD -> states 0,1,2,3,3,3,4,0; regwrite=1 only in state 4; total 7 cycles.
- sw, mem_ready=1 -> states 0,1,2,5; memwrite=1, iord=1 only in state 5; regwrite never asserts.
- Branch pcen:

  | Instruction | zero | pcen in S_BRANCH |
  |---|---|---|
  | beq | 1 | 1 |
  | beq | 0 | 0 |
  | bne | 1 | 0 |
  | bne | 0 | 1 |

- R-type with funct=101010 -> alucontrol=111 in S_RTYPEEX, regdst=1 in S_RTYPEWB; R-type with funct=000000 -> illegal pulse, next state 0, no regwrite.
- ori -> extop=1, alucontrol=001 in S_IMMEX; op=111111 -> illegal=1 in S_DECODE, then state 0; reset asserted in S_MEMWR -> memwrite=0 that cycle, state 0 next.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS sequencing controller.
package mips_mc_pkg;

  // Sequencer states; encodings are visible on state_o for debug.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // High-level ALU request from the sequencer; mc_aludec turns it into alucontrol.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_OR    = 2'd3
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // Datapath control word produced by the sequencer each cycle.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Next state out of S_DECODE for a given opcode; unsupported opcodes map to S_FETCH.
  function automatic state_t decode_next(logic [5:0] op);
    unique case (op)
      OP_LW, OP_SW:    decode_next = S_MEMADR;
      OP_RTYPE:        decode_next = S_RTYPEEX;
      OP_BEQ, OP_BNE:  decode_next = S_BRANCH;
      OP_ADDI, OP_ORI: decode_next = S_IMMEX;
      OP_J:            decode_next = S_JUMP;
      default:         decode_next = S_FETCH;
    endcase
  endfunction

  function automatic logic op_supported(logic [5:0] op);
    return decode_next(op) != S_FETCH;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle sequencer and its datapath.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       extop;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state_o;

  // Controller side: reads instruction fields and status, drives datapath controls.
  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, extop, pcsrc, pcen, alucontrol, illegal, state_o
  );

  // Datapath side.
  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, extop, pcsrc, pcen, alucontrol, illegal, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_aludec.sv
// ALU decoder: maps the sequencer's ALU request plus funct onto the 3-bit ALU code.
module mc_aludec
  import mips_mc_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_illegal_o
);

  // Combinational decode; funct is only consulted for R-type execution.
  always_comb begin
    alucontrol_o    = ALUC_ADD;
    funct_illegal_o = 1'b0;
    unique case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALUC_ADD;
      ALUOP_SUB: alucontrol_o = ALUC_SUB;
      ALUOP_OR:  alucontrol_o = ALUC_OR;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: alucontrol_o = ALUC_ADD;
          FUNCT_SUB: alucontrol_o = ALUC_SUB;
          FUNCT_AND: alucontrol_o = ALUC_AND;
          FUNCT_OR:  alucontrol_o = ALUC_OR;
          FUNCT_SLT: alucontrol_o = ALUC_SLT;
          default:   funct_illegal_o = 1'b1;
        endcase
      end
      default: alucontrol_o = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencer: steps one shared memory port/ALU through
// fetch, decode, execute, memory and writeback, stalling on mem_ready.
module multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);

  state_t     state_q, state_d;
  aluop_t     aluop;
  logic [2:0] alucontrol;
  logic       funct_illegal;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU request per state; kept apart from the FSM so funct decode feeds forward only.
  always_comb begin
    aluop = ALUOP_ADD;
    case (state_q)
      S_RTYPEEX: aluop = ALUOP_FUNCT;
      S_BRANCH:  aluop = ALUOP_SUB;
      S_IMMEX:   aluop = (bus.op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
      default:   aluop = ALUOP_ADD;
    endcase
  end

  mc_aludec u_aludec (
    .aluop_i        (aluop),
    .funct_i        (bus.funct),
    .alucontrol_o   (alucontrol),
    .funct_illegal_o(funct_illegal)
  );

  // Next-state and control decode for the current state.
  always_comb begin
    ctrl    = CTRL_IDLE;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        // PC + 4 computed on the ALU while the instruction is read.
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = 2'b01;
        if (bus.mem_ready) begin
          ctrl.irwrite = 1'b1;
          ctrl.pcen    = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded.
        ctrl.alusrcb = 2'b11;
        state_d      = decode_next(bus.op);
        ctrl.illegal = ~op_supported(bus.op);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        state_d      = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        // Write strobe held with the request until memory accepts it.
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b00;
        if (funct_illegal) begin
          ctrl.illegal = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_RTYPEWB;
        end
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b00;
        ctrl.pcsrc   = 2'b01;
        ctrl.pcen    = bus.zero ^ (bus.op == OP_BNE);
        state_d      = S_FETCH;
      end
      S_IMMEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.extop   = (bus.op == OP_ORI);
        state_d      = S_IMMWB;
      end
      S_IMMWB: begin
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pcsrc = 2'b10;
        ctrl.pcen  = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        // Unused encodings recover to fetch.
        state_d = S_FETCH;
      end
    endcase
  end

  // Suppress all architectural side effects while reset is held.
  always_comb begin
    ctrl_out = ctrl;
    if (reset) begin
      ctrl_out.pcen     = 1'b0;
      ctrl_out.irwrite  = 1'b0;
      ctrl_out.memwrite = 1'b0;
      ctrl_out.regwrite = 1'b0;
      ctrl_out.mem_req  = 1'b0;
      ctrl_out.illegal  = 1'b0;
    end
  end

  assign bus.mem_req    = ctrl_out.mem_req;
  assign bus.iord       = ctrl_out.iord;
  assign bus.memwrite   = ctrl_out.memwrite;
  assign bus.irwrite    = ctrl_out.irwrite;
  assign bus.regdst     = ctrl_out.regdst;
  assign bus.memtoreg   = ctrl_out.memtoreg;
  assign bus.regwrite   = ctrl_out.regwrite;
  assign bus.alusrca    = ctrl_out.alusrca;
  assign bus.alusrcb    = ctrl_out.alusrcb;
  assign bus.extop      = ctrl_out.extop;
  assign bus.pcsrc      = ctrl_out.pcsrc;
  assign bus.pcen       = ctrl_out.pcen;
  assign bus.illegal    = ctrl_out.illegal;
  assign bus.alucontrol = alucontrol;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, reset corner
// cases, and randomized instruction streams against an instruction-level model.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One expected cycle: drive hints (2 = random) plus required outputs.
  typedef struct {
    int       st;
    int       mr;
    int       zr;
    bit       pcen, irw, rw, mw, mreq, iord, ill, rdst, m2r, ext;
    bit [1:0] pcs;
    bit [2:0] aluc;
    bit       aluc_care;
  } exp_t;

  exp_t q[$];

  function automatic exp_t blank(int st);
    exp_t e;
    e = '{default: 0};
    e.st = st;
    e.mr = 2;
    e.zr = 2;
    e.aluc = 3'b010;
    e.aluc_care = 1'b1;
    return e;
  endfunction

  function automatic bit op_legal(logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J};
  endfunction

  function automatic void fdec(input logic [5:0] f, output bit ok, output logic [2:0] ac);
    ok = 1'b1;
    ac = 3'b010;
    case (f)
      6'b100000: ac = 3'b010;
      6'b100010: ac = 3'b110;
      6'b100100: ac = 3'b000;
      6'b100101: ac = 3'b001;
      6'b101010: ac = 3'b111;
      default:   ok = 1'b0;
    endcase
  endfunction

  // Instruction latency from the cycle-count table plus wait cycles.
  function automatic int cycles_of(logic [5:0] op, logic [5:0] f, int wf, int wm);
    bit ok;
    logic [2:0] ac;
    fdec(f, ok, ac);
    if (!op_legal(op)) return 2 + wf;
    case (op)
      OP_LW:          return 5 + wf + wm;
      OP_SW:          return 4 + wf + wm;
      OP_R:           return (ok ? 4 : 3) + wf;
      OP_ADDI, OP_ORI: return 4 + wf;
      default:        return 3 + wf;
    endcase
  endfunction

  // Expand one instruction into its expected per-cycle behaviour.
  task automatic build(input logic [5:0] op, input logic [5:0] funct, input bit zero,
                       input int wf, input int wm);
    exp_t e;
    bit ok;
    logic [2:0] ac;
    int st;
    q.delete();
    for (int i = 0; i < wf; i++) begin
      e = blank(0); e.mr = 0; e.mreq = 1; q.push_back(e);
    end
    e = blank(0); e.mr = 1; e.mreq = 1; e.pcen = 1; e.irw = 1; q.push_back(e);
    e = blank(1);
    if (!op_legal(op)) begin
      e.ill = 1; q.push_back(e);
      return;
    end
    q.push_back(e);
    case (op)
      OP_LW, OP_SW: begin
        q.push_back(blank(2));
        st = (op == OP_LW) ? 3 : 5;
        for (int i = 0; i <= wm; i++) begin
          e = blank(st); e.mr = (i == wm) ? 1 : 0; e.mreq = 1; e.iord = 1;
          e.mw = (op == OP_SW);
          q.push_back(e);
        end
        if (op == OP_LW) begin
          e = blank(4); e.rw = 1; e.m2r = 1; q.push_back(e);
        end
      end
      OP_R: begin
        fdec(funct, ok, ac);
        e = blank(6); e.aluc = ac;
        if (!ok) begin
          e.ill = 1; e.aluc_care = 0; q.push_back(e);
        end else begin
          q.push_back(e);
          e = blank(7); e.rw = 1; e.rdst = 1; q.push_back(e);
        end
      end
      OP_BEQ, OP_BNE: begin
        e = blank(8); e.zr = int'(zero); e.pcs = 2'b01; e.aluc = 3'b110;
        e.pcen = zero ^ (op == OP_BNE);
        q.push_back(e);
      end
      OP_ADDI, OP_ORI: begin
        e = blank(9); e.ext = (op == OP_ORI); e.aluc = (op == OP_ORI) ? 3'b001 : 3'b010;
        q.push_back(e);
        e = blank(10); e.rw = 1; q.push_back(e);
      end
      default: begin
        e = blank(11); e.pcs = 2'b10; e.pcen = 1; q.push_back(e);
      end
    endcase
  endtask

  // Drive one instruction cycle by cycle, compare every cycle, and measure latency.
  task automatic run(input logic [5:0] op, input logic [5:0] funct, input bit zero,
                     input int wf, input int wm, output int measured);
    exp_t e;
    bit seen;
    logic [18:0] act, exv;
    build(op, funct, zero, wf, wm);
    bus.op = op;
    bus.funct = funct;
    measured = -1;
    seen = 0;
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      bus.mem_ready = (e.mr == 2) ? 1'($urandom_range(0, 1)) : e.mr[0];
      bus.zero      = (e.zr == 2) ? 1'($urandom_range(0, 1)) : e.zr[0];
      #3;
      act = {bus.state_o, bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite, bus.mem_req,
             bus.iord, bus.illegal, bus.regdst, bus.memtoreg, bus.extop, bus.pcsrc,
             bus.alucontrol};
      exv = {e.st[3:0], e.pcen, e.irw, e.rw, e.mw, e.mreq, e.iord, e.ill, e.rdst, e.m2r,
             e.ext, e.pcs, e.aluc};
      if (!e.aluc_care) act[2:0] = exv[2:0];
      chk($sformatf("cycle op=%b funct=%b idx=%0d st=%0d", op, funct, i, e.st),
          32'(act), 32'(exv));
      if (bus.state_o == 4'd1) seen = 1;
      else if (seen && bus.state_o == 4'd0 && measured < 0) measured = i;
      step();
    end
    if (measured < 0 && seen && bus.state_o == 4'd0) measured = q.size();
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    bit         zero;
    int         wf;
    int         wm;
    int         cycles;
  } vec_t;

  vec_t tbl [0:15];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int meas;
    logic [5:0] op, funct;
    int k;
    logic [5:0] legal_ops [0:7];
    logic [5:0] legal_fn [0:4];

    tbl = '{
      '{OP_LW,   6'b000000, 1'b0, 0, 2, 7},
      '{OP_LW,   6'b000000, 1'b0, 0, 0, 5},
      '{OP_SW,   6'b000000, 1'b0, 0, 0, 4},
      '{OP_SW,   6'b000000, 1'b0, 1, 1, 6},
      '{OP_R,    6'b100000, 1'b0, 0, 0, 4},
      '{OP_R,    6'b101010, 1'b0, 0, 0, 4},
      '{OP_R,    6'b000000, 1'b0, 0, 0, 3},
      '{OP_BEQ,  6'b000000, 1'b1, 0, 0, 3},
      '{OP_BEQ,  6'b000000, 1'b0, 0, 0, 3},
      '{OP_BNE,  6'b000000, 1'b1, 0, 0, 3},
      '{OP_BNE,  6'b000000, 1'b0, 0, 0, 3},
      '{OP_ADDI, 6'b000000, 1'b0, 0, 0, 4},
      '{OP_ORI,  6'b000000, 1'b0, 2, 0, 6},
      '{OP_J,    6'b000000, 1'b0, 0, 0, 3},
      '{6'b111111, 6'b000000, 1'b0, 0, 0, 2},
      '{OP_R,    6'b100100, 1'b0, 1, 0, 5}
    };
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J};
    legal_fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Reset held two cycles with memory ready: no side effects, fetch state.
    reset = 1'b1;
    bus.op = OP_LW;
    bus.funct = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) begin
      step();
      chk("reset state", 32'(bus.state_o), 32'd0);
      chk("reset pcen/irwrite", 32'({bus.pcen, bus.irwrite}), 32'd0);
      chk("reset strobes", 32'({bus.memwrite, bus.regwrite, bus.mem_req, bus.illegal}), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("first fetch pcen/irwrite", 32'({bus.pcen, bus.irwrite}), 32'b11);

    // Directed vectors.
    for (int i = 0; i < 16; i++) begin
      run(tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].wf, tbl[i].wm, meas);
      chk($sformatf("cycles vec%0d", i), 32'(meas), 32'(tbl[i].cycles));
    end

    // Reset while a store waits on memory: strobe drops at once, fetch next.
    bus.op = OP_SW;
    bus.mem_ready = 1'b1;
    step();
    step();
    bus.mem_ready = 1'b0;
    step();
    chk("sw wait state", 32'(bus.state_o), 32'd5);
    chk("sw wait strobes", 32'({bus.memwrite, bus.mem_req, bus.iord}), 32'b111);
    reset = 1'b1;
    #1;
    chk("sw reset memwrite", 32'({bus.memwrite, bus.mem_req}), 32'd0);
    step();
    chk("sw reset next state", 32'(bus.state_o), 32'd0);
    reset = 1'b0;

    // Reset while a load waits on memory.
    bus.op = OP_LW;
    bus.mem_ready = 1'b1;
    step();
    step();
    bus.mem_ready = 1'b0;
    step();
    chk("lw wait state", 32'(bus.state_o), 32'd3);
    reset = 1'b1;
    #1;
    chk("lw reset strobes", 32'({bus.mem_req, bus.regwrite, bus.memwrite}), 32'd0);
    step();
    chk("lw reset next state", 32'(bus.state_o), 32'd0);
    reset = 1'b0;

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      funct = legal_fn[$urandom_range(0, 4)];
      if (k < 8) begin
        op = legal_ops[k];
      end else if (k == 8) begin
        op = 6'($urandom_range(0, 63));
        while (op_legal(op)) op = 6'($urandom_range(0, 63));
      end else begin
        op = OP_R;
        funct = 6'($urandom_range(0, 63));
      end
      begin
        int wf, wm;
        bit z;
        wf = $urandom_range(0, 3);
        wm = $urandom_range(0, 3);
        z = 1'($urandom_range(0, 1));
        run(op, funct, z, wf, wm, meas);
        chk($sformatf("cycles rand%0d op=%b", n, op), 32'(meas),
            32'(cycles_of(op, funct, wf, wm)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
